// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM backing-store controller.
package arm_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_WR_LO,
      ST_WR_HI,
      ST_DONE
   } sram_state_t;

   localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1 while enabled and flags the
// final cycle so the FSM knows when to advance.
module sram_phase_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   logic [3:0] cnt_q, cnt_d;

   assign last = (cnt_q == 4'(WAIT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = last ? '0 : cnt_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two 16-bit async SRAM accesses, stalling the
// pipeline through ready until the DONE cycle.
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        ALU_Res,
   input  logic [31:0]        VAL_Rm,
   output logic [31:0]        MEM_Res,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [15:0]        SRAM_DQ_O,
   output logic               SRAM_DQ_OE,
   input  logic [15:0]        SRAM_DQ_I,
   output logic               SRAM_WE_N
);

   sram_state_t state_q, state_d;
   logic [15:0] lo_buf_q, lo_buf_d;
   logic [31:0] mem_res_q, mem_res_d;

   logic        acc, wr_st, hi_st, last;
   logic [31:0] addr_a;
   logic        unused_addr_bits;

   sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (!acc),
      .en   (acc),
      .last (last)
   );

   assign acc   = (state_q == ST_RD_LO) || (state_q == ST_RD_HI) ||
                  (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
   assign wr_st = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
   assign hi_st = (state_q == ST_RD_HI) || (state_q == ST_WR_HI);

   // Byte address relative to the SRAM window; the byte lane bits are dropped.
   assign addr_a           = ALU_Res - ADDR_BASE;
   assign unused_addr_bits = ^{addr_a[31:SRAM_AW+1], addr_a[1:0]};

   assign SRAM_ADDR  = acc ? {addr_a[SRAM_AW:2], (hi_st ? HALF_HI : HALF_LO)} : '0;
   assign SRAM_DQ_OE = wr_st;
   assign SRAM_DQ_O  = wr_st ? (hi_st ? VAL_Rm[31:16] : VAL_Rm[15:0]) : 16'h0000;
   // Strobe released on the final cycle of each phase for address/data hold.
   assign SRAM_WE_N  = !(wr_st && !last);
   assign MEM_Res    = mem_res_q;

   assign ready = !(acc || ((state_q == ST_IDLE) && (MEM_R_EN || MEM_W_EN)));

   always_comb begin
      state_d   = state_q;
      lo_buf_d  = lo_buf_q;
      mem_res_d = mem_res_q;
      case (state_q)
         ST_IDLE: begin
            if (MEM_W_EN)
               state_d = ST_WR_LO;
            else if (MEM_R_EN)
               state_d = ST_RD_LO;
         end
         ST_RD_LO: begin
            if (last) begin
               lo_buf_d = SRAM_DQ_I;
               state_d  = ST_RD_HI;
            end
         end
         ST_RD_HI: begin
            if (last) begin
               mem_res_d = {SRAM_DQ_I, lo_buf_q};
               state_d   = ST_DONE;
            end
         end
         ST_WR_LO: if (last) state_d = ST_WR_HI;
         ST_WR_HI: if (last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         lo_buf_q  <= '0;
         mem_res_q <= '0;
      end else begin
         state_q   <= state_d;
         lo_buf_q  <= lo_buf_d;
         mem_res_q <= mem_res_d;
      end
   end

endmodule
